zone_sensor_scheduler: RTL and testbench
========================================

# zone_sensor_scheduler

Shares one multiplexed temperature sensor between ZONES thermal zones, each zone running its own heater/cooler controller. It starts a periodic scan of all zones, serves urgent resample requests ahead of the scan, and runs a req/ack handshake with the sensor front end. Each captured sample is published with its zone index so the downstream per-zone controllers can update. Sensor timeouts are flagged per zone.

## Interface
- ZONES, 4: number of zones, 2..16; ZW = clog2(ZONES).
- PERIOD, 1000: cycles between scan starts, ≥ 4·ZONES.
- TIMEOUT, 16: max cycles sns_req stays high awaiting ack, ≥ 2.
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  allows the period counter to run and new transactions to start.
- urgent_req  in  ZONES  level request for an immediate resample per zone.
- fault_clr  in  1  clears fault and scan_overrun.
- sns_req  out  1  sensor conversion request.
- sns_zone  out  ZW  zone being sampled; stable while sns_req is high.
- sns_ack  in  1  sample ready; qualifies sns_data this cycle.
- sns_data  in  8  signed sample, °C.
- temp_valid  out  1  one-cycle publish strobe.
- temp_zone  out  ZW  zone of the published sample.
- temp_value  out  8  signed published sample.
- fault  out  ZONES  sticky per-zone timeout flags.
- scan_overrun  out  1  sticky; a new scan started while the previous scan was unfinished.

## Operation
- FSM states: IDLE, WAIT, PUBLISH.
- **Pending sets:**
  - scan_pend[ZONES]: all bits set when the period counter wraps.
  - urg_pend[ZONES]: ORs in urgent_req every cycle.
  - Serving zone z clears both scan_pend[z] and urg_pend[z], whether the transaction ends in ack or timeout. A clear and a new urgent_req in the same cycle leave urg_pend[z] set.
- **Grant, in IDLE with enable=1 and any bit pending:**
  - The lowest-index urg_pend bit wins.
  - Otherwise scan_pend is served round-robin starting at rr_ptr, wrapping.
  - A scan grant sets rr_ptr = z+1 mod ZONES. An urgent grant leaves rr_ptr unchanged.
  - The grant registers sns_zone=z, sets sns_req=1 and moves to WAIT.
- **WAIT:**
  - On sns_ack: capture sns_data into temp_value and sns_zone into temp_zone, drop sns_req, go to PUBLISH.
  - If TIMEOUT cycles pass without ack: drop sns_req, set fault[z], return to IDLE, publish nothing.
- **PUBLISH:** temp_valid=1 for one cycle, then IDLE.
- **enable=0:**
  - An in-flight transaction completes normally (ack or timeout).
  - No new grants are made.
  - The period counter is held at 0.
  - Pending bits keep accumulating urgent requests.
- **Period counter:** runs 0..PERIOD-1 while enabled. At the wrap, if scan_pend≠0 then scan_overrun is set, and scan_pend is then set to all ones.
- **fault_clr:** clears fault and scan_overrun. A set in the same cycle wins.
- **Reset values:** every output is 0, the FSM is in IDLE, rr_ptr=0, both pending sets are 0, and counters are 0.

## Timing
- Grant: pending bit visible in IDLE at cycle N → sns_req=1 at N+1.
- Ack sampled at cycle M → temp_valid=1 at M+1 with the captured data → IDLE at M+2, so the next sns_req can rise at M+3.
- Ack in the first WAIT cycle is legal (zero-wait sensor).
- Timeout: sns_req is high for exactly TIMEOUT cycles; fault[z] is visible the cycle after sns_req falls.
- temp_zone and temp_value hold their value until the next publish.
- sns_ack outside WAIT is ignored.
- Asserting reset_n low mid-transaction drops sns_req and temp_valid immediately; no sample is published.
- Throughput: at most one sample per 3 cycles.

## Structure
- Shared package thermal_pkg holds:
  - the TEMP_W=8 constant;
  - the sched_state_t enum (IDLE, WAIT, PUBLISH);
  - the zone-width function clog2-based ZW.
- Sub-module rr_picker: combinational; inputs req vector and start pointer; outputs grant index and a valid flag. Used for the scan_pend search.
- Lowest-index urgent search is inline.

## Test plan
Parameters for all scenarios: ZONES=4, PERIOD=64, TIMEOUT=8.
- Reset release, enable=1, ack 3 cycles after each req, sns_data=20,-5,40,12 → zones granted in order 0,1,2,3; temp_valid ×4 with matching temp_zone/temp_value; all outputs were 0 during reset.
- urgent_req[2] pulsed while zone 0 is in WAIT → after zone 0 publishes, zone 2 is granted next, then zones 1,3; rr_ptr unaffected by the urgent grant.
- Never ack zone 1 → sns_req high exactly 8 cycles, fault=4'b0010, no temp_valid for zone 1, zone 2 granted next; fault_clr → fault=0.
- Ack delayed 20 cycles per zone so the scan takes >64 cycles → scan_overrun=1 at the second wrap; fault_clr and a new overrun in the same cycle → scan_overrun stays 1.
- enable dropped while zone 3 is in WAIT → zone 3 still publishes; no further sns_req; period counter stays 0 while urgent_req[0] accumulates; re-enable → zone 0 granted first.
- reset_n asserted low during WAIT → sns_req=0 immediately, temp_valid never pulses, rr_ptr=0 after release.

Source files
------------

// File: rtl/thermal_pkg.sv
// Shared types and constants for the thermal zone control blocks.
package thermal_pkg;

    localparam int TEMP_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PUBLISH
    } sched_state_t;

    function automatic int zone_w(input int zones);
        return (zones > 1) ? $clog2(zones) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search: first set bit of req at or after start, wrapping.
// Purely combinational, zero latency; no backpressure.
module rr_picker #(
    parameter int ZONES = 4,
    parameter int ZW    = 2
) (
    input  logic [ZONES-1:0] req,
    input  logic [ZW-1:0]    start,
    output logic [ZW-1:0]    grant,
    output logic             grant_vld
);

    logic [ZW:0]   sum;
    logic [ZW-1:0] k;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        sum       = '0;
        k         = '0;
        for (int i = 0; i < ZONES; i++) begin
            sum = {1'b0, start} + (ZW+1)'(i);
            if (sum >= (ZW+1)'(ZONES))
                sum = sum - (ZW+1)'(ZONES);
            k = sum[ZW-1:0];
            if (!grant_vld && req[k]) begin
                grant     = k;
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/zone_sensor_scheduler.sv
// Shares one sensor between ZONES zones: periodic scan plus urgent resamples, req/ack to the sensor.
// Grant 1 cycle after a pending bit is seen; publish 1 cycle after ack; one sample per 3 cycles at most.
module zone_sensor_scheduler
    import thermal_pkg::*;
#(
    parameter int ZONES   = 4,
    parameter int PERIOD  = 1000,
    parameter int TIMEOUT = 16,
    localparam int ZW     = zone_w(ZONES)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [ZONES-1:0]         urgent_req,
    input  logic                     fault_clr,
    output logic                     sns_req,
    output logic [ZW-1:0]            sns_zone,
    input  logic                     sns_ack,
    input  logic signed [TEMP_W-1:0] sns_data,
    output logic                     temp_valid,
    output logic [ZW-1:0]            temp_zone,
    output logic signed [TEMP_W-1:0] temp_value,
    output logic [ZONES-1:0]         fault,
    output logic                     scan_overrun
);

    localparam int CW = $clog2(PERIOD);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t     state;
    logic [ZONES-1:0] scan_pend;
    logic [ZONES-1:0] urg_pend;
    logic [ZW-1:0]    rr_ptr;
    logic [CW-1:0]    period_cnt;
    logic [TW-1:0]    wait_cnt;

    logic [ZW-1:0]    scan_idx;
    logic             scan_vld;
    logic [ZW-1:0]    urg_idx;
    logic             urg_vld;
    logic             in_wait;
    logic             expired;
    logic             served;
    logic             wrap;
    logic [ZONES-1:0] clr_mask;

    rr_picker #(
        .ZONES (ZONES),
        .ZW    (ZW)
    ) u_rr_picker (
        .req       (scan_pend),
        .start     (rr_ptr),
        .grant     (scan_idx),
        .grant_vld (scan_vld)
    );

    // Descending scan so the lowest pending index is the last one written.
    always_comb begin
        urg_idx = '0;
        urg_vld = 1'b0;
        for (int i = ZONES - 1; i >= 0; i--) begin
            if (urg_pend[i]) begin
                urg_idx = ZW'(i);
                urg_vld = 1'b1;
            end
        end
    end

    assign in_wait = (state == WAIT);
    assign expired = in_wait && !sns_ack && (wait_cnt == TW'(TIMEOUT - 1));
    assign served  = in_wait && (sns_ack || expired);
    assign wrap    = enable && (period_cnt == CW'(PERIOD - 1));

    always_comb begin
        clr_mask = '0;
        if (served)
            clr_mask[sns_zone] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sns_req    <= 1'b0;
            sns_zone   <= '0;
            temp_valid <= 1'b0;
            temp_zone  <= '0;
            temp_value <= '0;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    temp_valid <= 1'b0;
                    if (enable && (urg_vld || scan_vld)) begin
                        sns_req  <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WAIT;
                        if (urg_vld) begin
                            sns_zone <= urg_idx;
                        end else begin
                            sns_zone <= scan_idx;
                            rr_ptr   <= (scan_idx == ZW'(ZONES - 1)) ? '0 : scan_idx + ZW'(1);
                        end
                    end
                end
                WAIT: begin
                    if (sns_ack) begin
                        temp_value <= sns_data;
                        temp_zone  <= sns_zone;
                        temp_valid <= 1'b1;
                        sns_req    <= 1'b0;
                        state      <= PUBLISH;
                    end else if (expired) begin
                        sns_req <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                PUBLISH: begin
                    temp_valid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    sns_req    <= 1'b0;
                    temp_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // A wrap refills scan_pend even if the last zone finishes in that same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_pend    <= '0;
            urg_pend     <= '0;
            period_cnt   <= '0;
            fault        <= '0;
            scan_overrun <= 1'b0;
        end else begin
            urg_pend   <= (urg_pend & ~clr_mask) | urgent_req;
            scan_pend  <= wrap ? '1 : (scan_pend & ~clr_mask);
            period_cnt <= (enable && !wrap) ? period_cnt + CW'(1) : '0;
            fault      <= (fault_clr ? '0 : fault) | (expired ? clr_mask : '0);
            if (wrap && (scan_pend != '0))
                scan_overrun <= 1'b1;
            else if (fault_clr)
                scan_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_zone_sensor_scheduler.sv
// Randomised bench for zone_sensor_scheduler against a cycle-stepped behavioural model.
module tb_zone_sensor_scheduler;

    localparam int ZONES   = 4;
    localparam int PERIOD  = 64;
    localparam int TIMEOUT = 8;
    localparam int NCYC    = 1800;
    localparam int NEVER   = 99;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic [ZONES-1:0]  urgent_req = '0;
    logic              fault_clr = 1'b0;
    logic              sns_req;
    logic [1:0]        sns_zone;
    logic              sns_ack = 1'b0;
    logic signed [7:0] sns_data = '0;
    logic              temp_valid;
    logic [1:0]        temp_zone;
    logic signed [7:0] temp_value;
    logic [ZONES-1:0]  fault;
    logic              scan_overrun;

    zone_sensor_scheduler #(
        .ZONES   (ZONES),
        .PERIOD  (PERIOD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .urgent_req   (urgent_req),
        .fault_clr    (fault_clr),
        .sns_req      (sns_req),
        .sns_zone     (sns_zone),
        .sns_ack      (sns_ack),
        .sns_data     (sns_data),
        .temp_valid   (temp_valid),
        .temp_zone    (temp_zone),
        .temp_value   (temp_value),
        .fault        (fault),
        .scan_overrun (scan_overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: pending sets as bit arrays, transaction as (busy, age, publish) flags.
    bit                m_scan [ZONES];
    bit                m_urg  [ZONES];
    bit                m_fault[ZONES];
    bit                m_req, m_pub, m_ovr;
    int                m_rr, m_per, m_zone, m_age, m_delay, m_tz;
    logic signed [7:0] m_tv;

    task automatic model_reset();
        for (int z = 0; z < ZONES; z++) begin
            m_scan[z] = 1'b0; m_urg[z] = 1'b0; m_fault[z] = 1'b0;
        end
        m_req = 1'b0; m_pub = 1'b0; m_ovr = 1'b0;
        m_rr = 0; m_per = 0; m_zone = 0; m_age = 0; m_delay = 0; m_tz = 0; m_tv = '0;
    endtask

    function automatic logic [ZONES-1:0] fault_vec();
        logic [ZONES-1:0] f = '0;
        for (int z = 0; z < ZONES; z++) f[z] = m_fault[z];
        return f;
    endfunction

    task automatic model_step(input bit en, input logic [ZONES-1:0] ur, input bit ack,
                              input logic signed [7:0] dat, input bit fclr, input int nxt_delay);
        int  done = -1;
        bit  timed_out = 1'b0;
        bit  any_scan = 1'b0;
        bit  wrapped;
        int  g = -1;
        bit  from_scan = 1'b0;
        for (int z = 0; z < ZONES; z++) any_scan |= m_scan[z];
        wrapped = en && (m_per == PERIOD - 1);
        if (m_pub) begin
            m_pub = 1'b0;
        end else if (m_req) begin
            if (ack) begin
                m_tv = dat; m_tz = m_zone; m_req = 1'b0; m_pub = 1'b1; done = m_zone;
            end else if (m_age == TIMEOUT - 1) begin
                m_req = 1'b0; done = m_zone; timed_out = 1'b1;
            end else begin
                m_age++;
            end
        end else if (en) begin
            for (int z = ZONES - 1; z >= 0; z--) if (m_urg[z]) g = z;
            if (g < 0) begin
                for (int i = ZONES - 1; i >= 0; i--)
                    if (m_scan[(m_rr + i) % ZONES]) g = (m_rr + i) % ZONES;
                from_scan = (g >= 0);
            end
            if (g >= 0) begin
                m_req = 1'b1; m_zone = g; m_age = 0; m_delay = nxt_delay;
                if (from_scan) m_rr = (g + 1) % ZONES;
            end
        end
        for (int z = 0; z < ZONES; z++) begin
            m_urg[z]  = (m_urg[z] && z != done) || ur[z];
            m_scan[z] = wrapped ? 1'b1 : (m_scan[z] && z != done);
        end
        if (fclr) begin
            m_ovr = 1'b0;
            for (int z = 0; z < ZONES; z++) m_fault[z] = 1'b0;
        end
        if (wrapped && any_scan) m_ovr = 1'b1;
        if (timed_out) m_fault[done] = 1'b1;
        m_per = (en && !wrapped) ? m_per + 1 : 0;
    endtask

    task automatic compare();
        check("sns_req", 32'(sns_req), 32'(m_req));
        if (m_req) check("sns_zone", 32'(sns_zone), 32'(m_zone));
        check("temp_valid", 32'(temp_valid), 32'(m_pub));
        check("temp_zone", 32'(temp_zone), 32'(m_tz));
        check("temp_value", 32'(temp_value), 32'(m_tv));
        check("fault", 32'(fault), 32'(fault_vec()));
        check("scan_overrun", 32'(scan_overrun), 32'(m_ovr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sns_req"}, 32'(sns_req), 32'd0);
        check({tag, "_sns_zone"}, 32'(sns_zone), 32'd0);
        check({tag, "_temp_valid"}, 32'(temp_valid), 32'd0);
        check({tag, "_temp_zone"}, 32'(temp_zone), 32'd0);
        check({tag, "_temp_value"}, 32'(temp_value), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_overrun"}, 32'(scan_overrun), 32'd0);
    endtask

    initial begin
        bit                en_r = 1'b1;
        bit                did_rst = 1'b0;
        bit                en, ack, fclr;
        logic [ZONES-1:0]  ur;
        logic signed [7:0] dat;
        int                dly, r;

        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            compare();
            if (cyc >= 600 && !did_rst && m_req) begin
                did_rst = 1'b1;
                reset_n = 1'b0;
                #1;
                check_all_zero("midreset");
                enable = 1'b0; urgent_req = '0; sns_ack = 1'b0; fault_clr = 1'b0;
                model_reset();
                repeat (3) begin
                    @(negedge clk);
                    check("rst_sns_req", 32'(sns_req), 32'd0);
                    check("rst_temp_valid", 32'(temp_valid), 32'd0);
                end
                reset_n = 1'b1;
            end else begin
                ur   = '0;
                fclr = 1'b0;
                dat  = 8'($urandom);
                if (cyc < 200) begin
                    en = 1'b1; dly = 3;
                end else if (cyc < 900) begin
                    if ($urandom_range(39) == 0) en_r = !en_r;
                    en = en_r;
                    for (int z = 0; z < ZONES; z++) ur[z] = ($urandom_range(23) == 0);
                    r = $urandom_range(5);
                    dly = (r == 5) ? NEVER : r;
                    fclr = ($urandom_range(19) == 0);
                end else if (cyc < 1500) begin
                    en = 1'b1; dly = 20;
                    for (int z = 0; z < ZONES; z++) ur[z] = ($urandom_range(63) == 0);
                    fclr = (m_per == PERIOD - 1) || ($urandom_range(5) == 0);
                end else begin
                    en = ((cyc / 40) % 2) == 0;
                    for (int z = 0; z < ZONES; z++) ur[z] = ($urandom_range(15) == 0);
                    dly = $urandom_range(4);
                    fclr = ($urandom_range(19) == 0);
                end
                ack = (m_req && m_age == m_delay) ||
                      (!m_req && cyc >= 200 && $urandom_range(9) == 0);
                model_step(en, ur, ack, dat, fclr, dly);
                enable     = en;
                urgent_req = ur;
                sns_ack    = ack;
                sns_data   = dat;
                fault_clr  = fclr;
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
